// File: rtl/data_fifo_param.sv
// -----------------------------------------------------------------------------
// data_fifo_param
//   Parametrised first-word-fall-through FIFO that stages plaintext words
//   between the USB receive path (writer) and the AES block loader (reader).
//   It provides an occupancy count, programmable almost-full and almost-empty
//   flags, a synchronous flush, and a block_ready flag that is set once a full
//   AES block of words is buffered.
//
// Parameters
//   DATA_WIDTH  bits per word
//   DEPTH       number of entries (power of 2, >= 4)
//   AF_LEVEL    almost_full  when count >= AF_LEVEL
//   AE_LEVEL    almost_empty when count <= AE_LEVEL
//   BLOCK_WORDS block_ready  when count >= BLOCK_WORDS (1..DEPTH)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear of contents (beats any access that cycle)
//   w_enable     write request,  w_data write word
//   r_enable     pop request,    r_data head word (fall-through)
//   empty/full/almost_full/almost_empty/block_ready  decodes of count
//   count        occupancy 0..DEPTH
//
// Optional feature, enabled by defining DATA_FIFO_ERR_EN:
//   err_clr      input, clears the sticky error flags
//   overflow     sticky, set by a write rejected because the FIFO is full
//   underflow    sticky, set by a read of an empty FIFO
// -----------------------------------------------------------------------------
module data_fifo_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       w_enable,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       r_enable,
`ifdef DATA_FIFO_ERR_EN
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       block_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the counter so the flag compares are width-matched.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] BLK_C   = (AW+1)'(BLOCK_WORDS);
  localparam logic [AW:0] ZERO_C  = (AW+1)'(0);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [AW:0]           cnt_q,  cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic empty_s;
  logic full_s;
  logic wr_acc_s;
  logic rd_acc_s;
  logic mem_we_s;

  assign empty_s = (cnt_q == ZERO_C);
  assign full_s  = (cnt_q == DEPTH_C);

  // A write into a full FIFO is only legal when a pop frees a slot that edge.
  assign rd_acc_s = r_enable & ~empty_s;
  assign wr_acc_s = w_enable & (~full_s | rd_acc_s);
  assign mem_we_s = wr_acc_s & ~flush;

  // Next-state for pointers and occupancy; flush wins over any access.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = PTR_ZERO_C;
      rptr_d = PTR_ZERO_C;
      cnt_d  = ZERO_C;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + PTR_ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + PTR_ONE_C;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= PTR_ZERO_C;
      rptr_q <= PTR_ZERO_C;
      cnt_q  <= ZERO_C;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; deliberately not reset, contents are dead after rst/flush.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wptr_q] <= w_data;
    end
  end

  // Status is decoded from the count register only, never from the requests.
  assign r_data       = mem_q[rptr_q];
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign block_ready  = (cnt_q >= BLK_C);
  assign count        = cnt_q;

`ifdef DATA_FIFO_ERR_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;
  logic ovf_evt_s;
  logic udf_evt_s;

  // A read on an empty FIFO that carries a concurrent write is not an error:
  // the write is accepted and the read simply has nothing to pop yet.
  assign ovf_evt_s = w_enable & full_s & ~r_enable;
  assign udf_evt_s = r_enable & empty_s & ~w_enable;

  // Sticky error flags; a new event beats err_clr in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (ovf_evt_s) begin
        overflow_d = 1'b1;
      end else if (err_clr) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
      if (udf_evt_s) begin
        underflow_d = 1'b1;
      end else if (err_clr) begin
        underflow_d = 1'b0;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_data_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_data_fifo_param
//   Self-checking bench for data_fifo_param at default parameters (8 x 16).
//   A queue holds the words the FIFO should contain; words are pushed when a
//   write is accepted and popped when a read is accepted, and the popped value
//   is compared with the r_data observed before the edge.
// -----------------------------------------------------------------------------
module tb_data_fifo_param;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       w_enable;
  logic [7:0] w_data;
  logic       r_enable;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic       block_ready;
  logic [4:0] count;
`ifdef DATA_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  data_fifo_param #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2),
    .BLOCK_WORDS(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .r_enable    (r_enable),
`ifdef DATA_FIFO_ERR_EN
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .block_ready (block_ready),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus. Scoreboard bookkeeping follows the accept rules;
  // the caller compares got/exp. Returns at posedge+1 with requests dropped.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                     output logic popped, output logic [7:0] got,
                     output logic [7:0] exp);
    int   n;
    logic rd_ok;
    logic wr_ok;
    n      = sb.size();
    rd_ok  = re && (n > 0);
    wr_ok  = we && ((n < 16) || rd_ok);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    got    = r_data;
    exp    = 8'h00;
    popped = rd_ok;
    if (rd_ok) exp = sb.pop_front();
    if (wr_ok) sb.push_back(wd);
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; w_enable = 1'b0; r_enable = 1'b0; w_data = 8'h00;
`ifdef DATA_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    #12;
    checks++;
    if ({empty, full, almost_empty, almost_full, block_ready} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_flags got=%b required=10100",
               {empty, full, almost_empty, almost_full, block_ready});
    end
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL reset_count got=%0d required=0", count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    logic p; logic [7:0] g, e;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, p, g, e);
      checks++;
      if (count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count i=%0d got=%0d required=%0d", i, count, i + 1);
      end
      checks++;
      if ({full, almost_full, block_ready, almost_empty, empty} !==
          {(i == 15), (i >= 13), (i == 15), (i <= 1), 1'b0}) begin
        errors++;
        $display("FAIL fill_flags i=%0d got=%b required=%b", i,
                 {full, almost_full, block_ready, almost_empty, empty},
                 {(i == 15), (i >= 13), (i == 15), (i <= 1), 1'b0});
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, p, g, e);
      checks++;
      if (!p || g !== e || g !== 8'(i)) begin
        errors++; $display("FAIL drain_data i=%0d got=%h required=%h", i, g, 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL drain_empty got empty=%b count=%0d required 1/0", empty, count);
    end
  endtask

  task automatic test_overflow();
    logic p; logic [7:0] g, e;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, p, g, e);
    cyc(1'b1, 8'hAA, 1'b0, p, g, e);
    checks++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_count got=%0d full=%b required=16/1", count, full);
    end
`ifdef DATA_FIFO_ERR_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got=%b required=1", overflow);
    end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got=%b required=0", overflow);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, p, g, e);
      checks++;
      if (g !== e || g !== 8'(8'h20 + i)) begin
        errors++; $display("FAIL ovf_data i=%0d got=%h required=%h", i, g, 8'(8'h20 + i));
      end
    end
  endtask

  task automatic test_full_rw();
    logic p; logic [7:0] g, e;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, p, g, e);
    cyc(1'b1, 8'h55, 1'b1, p, g, e);
    checks++;
    if (g !== 8'h00 || g !== e) begin
      errors++; $display("FAIL full_rw_pop got=%h required=00", g);
    end
    checks++;
    if (count !== 5'd16) begin
      errors++; $display("FAIL full_rw_count got=%0d required=16", count);
    end
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, p, g, e);
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL full_rw_data i=%0d got=%h required=%h", i, g, e);
      end
    end
    checks++;
    if (r_data !== 8'h55 || count !== 5'd1) begin
      errors++; $display("FAIL full_rw_new got=%h cnt=%0d required=55/1", r_data, count);
    end
    cyc(1'b0, 8'h00, 1'b1, p, g, e);
  endtask

  task automatic test_empty_rw();
    logic p; logic [7:0] g, e;
    cyc(1'b1, 8'h3C, 1'b1, p, g, e);
    checks++;
    if (count !== 5'd1 || empty !== 1'b0 || r_data !== 8'h3C) begin
      errors++;
      $display("FAIL empty_rw got cnt=%0d empty=%b data=%h required 1/0/3c", count, empty, r_data);
    end
`ifdef DATA_FIFO_ERR_EN
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL empty_rw_udf got=%b required=0", underflow);
    end
`endif
    cyc(1'b0, 8'h00, 1'b1, p, g, e);
    checks++;
    if (g !== e || g !== 8'h3C) begin
      errors++; $display("FAIL empty_rw_pop got=%h required=3c", g);
    end
    cyc(1'b0, 8'h00, 1'b1, p, g, e);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_read got cnt=%0d empty=%b required 0/1", count, empty);
    end
  endtask

  task automatic test_flush();
    logic p; logic [7:0] g, e;
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, p, g, e);
    checks++;
    if (count !== 5'd9) begin
      errors++; $display("FAIL flush_pre got=%0d required=9", count);
    end
    flush = 1'b1; w_enable = 1'b1; w_data = 8'h99;
    @(posedge clk); #1;
    flush = 1'b0; w_enable = 1'b0;
    sb.delete();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL flush_clear got cnt=%0d empty=%b required 0/1", count, empty);
    end
    cyc(1'b1, 8'h11, 1'b0, p, g, e);
    checks++;
    if (r_data !== 8'h11 || count !== 5'd1) begin
      errors++; $display("FAIL flush_next got=%h cnt=%0d required=11/1", r_data, count);
    end
    cyc(1'b0, 8'h00, 1'b1, p, g, e);
  endtask

  task automatic test_async_reset();
    logic p; logic [7:0] g, e;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, p, g, e);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++; $display("FAIL async_rst got empty=%b cnt=%0d required 1/0", empty, count);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b1, p, g, e);
      if (i > 0) begin
        checks++;
        if (!p || g !== e || g !== 8'(8'h40 + i - 1)) begin
          errors++; $display("FAIL wrap_data i=%0d got=%h required=%h", i, g, 8'(8'h40 + i - 1));
        end
      end
    end
    cyc(1'b0, 8'h00, 1'b1, p, g, e);
    checks++;
    if (g !== 8'h53 || count !== 5'd0) begin
      errors++; $display("FAIL wrap_last got=%h cnt=%0d required=53/0", g, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
